// File: rtl/image_tx_pkg.sv
// -----------------------------------------------------------------------------
// image_tx_pkg
// Shared definitions for the pixel-stream transmitter:
//   - default frame geometry and fixed-point sample width (W) / address width (AW)
//   - controller state encoding
//   - cnt_w(): width needed for a counter that must hold 0..limit without wrap
//   - counter widths of the default configuration
// -----------------------------------------------------------------------------
package image_tx_pkg;

  localparam int DEF_INTEGER_BITS     = 9;
  localparam int DEF_FIXED_POINT_BITS = 4;
  localparam int DEF_IMG_WIDTH        = 28;
  localparam int DEF_IMG_HEIGHT       = 28;
  localparam int DEF_ROW_GAP          = 2;
  localparam int DEF_FLUSH_CYCLES     = 4;
  localparam int DEF_TIMEOUT_CYCLES   = 4096;

  localparam int W     = DEF_INTEGER_BITS + DEF_FIXED_POINT_BITS;
  localparam int DEF_N = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
  localparam int AW    = $clog2(DEF_N);

  // Width of a counter holding values 0..limit; never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  localparam int COL_CNT_W = cnt_w(DEF_IMG_WIDTH - 1);
  localparam int ROW_CNT_W = cnt_w(DEF_IMG_HEIGHT - 1);
  localparam int GAP_CNT_W = cnt_w(DEF_ROW_GAP);
  localparam int TMO_CNT_W = cnt_w(DEF_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    KLOAD,
    STREAM,
    WAIT,
    DONE
  } state_e;

endpackage : image_tx_pkg

// File: rtl/frame_buffer.sv
// -----------------------------------------------------------------------------
// frame_buffer
// Simple dual-port RAM holding one frame, DEPTH x WIDTH.
//   clk, rst_n         clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i  write port, written on the rising edge
//   re_i/raddr_i       read request; data appears on rdata_o one cycle later
//   rdata_o            read register; holds its value when no read is issued
// -----------------------------------------------------------------------------
module frame_buffer
  import image_tx_pkg::*;
#(
  parameter int WIDTH  = W,
  parameter int DEPTH  = DEF_N,
  parameter int ADDR_W = AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // read register is reset, which is what the outside world can observe.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : frame_buffer

// File: rtl/image_stream_tx.sv
// -----------------------------------------------------------------------------
// image_stream_tx
// Transmit end of the pixel stream feeding the image pipeline. The host fills
// a one-frame buffer through a write port; on start the block flushes the
// pipeline, strobes the kernel load, streams the frame row by row with idle
// gaps between rows, then waits for the two-neuron result.
//
// Ports:
//   axi_clk, axi_reset_n      clock, async active-low reset
//   wr_en, wr_addr, wr_data   frame-buffer write (honoured only when idle)
//   start, kernel_vals_in     frame request; kernel sampled on accepted start
//   o_pipe_rst_n              downstream pipeline reset (low during flush)
//   o_kernel_reset            one-cycle kernel load strobe
//   o_kernel_vals             kernel captured at start
//   o_data_valid, o_data      pixel stream; o_data holds while invalid
//   res_valid, res_data       pipeline result
//   result                    first result of the frame
//   busy, done, o_error       status: not idle / completion pulse / timeout
// -----------------------------------------------------------------------------
module image_stream_tx
  import image_tx_pkg::*;
#(
  parameter int INTEGER_BITS     = DEF_INTEGER_BITS,
  parameter int FIXED_POINT_BITS = DEF_FIXED_POINT_BITS,
  parameter int IMG_WIDTH        = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT       = DEF_IMG_HEIGHT,
  parameter int ROW_GAP          = DEF_ROW_GAP,
  parameter int FLUSH_CYCLES     = DEF_FLUSH_CYCLES,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
  localparam int PIX_W  = INTEGER_BITS + FIXED_POINT_BITS,
  localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT,
  localparam int ADDR_W = $clog2(NPIX)
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [PIX_W-1:0]     wr_data,
  input  logic                 start,
  input  logic [9*PIX_W-1:0]   kernel_vals_in,
  output logic                 o_pipe_rst_n,
  output logic                 o_kernel_reset,
  output logic [9*PIX_W-1:0]   o_kernel_vals,
  output logic                 o_data_valid,
  output logic [PIX_W-1:0]     o_data,
  input  logic                 res_valid,
  input  logic [2*PIX_W-1:0]   res_data,
  output logic [2*PIX_W-1:0]   result,
  output logic                 busy,
  output logic                 done,
  output logic                 o_error
);

  localparam int COL_W   = cnt_w(IMG_WIDTH - 1);
  localparam int ROW_W   = cnt_w(IMG_HEIGHT - 1);
  localparam int GAP_W   = cnt_w(ROW_GAP);
  localparam int FLUSH_W = cnt_w(FLUSH_CYCLES);
  localparam int TMO_W   = cnt_w(TIMEOUT_CYCLES);

  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(ROW_GAP);
  localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [TMO_W-1:0]   LAST_WAIT  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W:0]    NPIX_LIM   = (ADDR_W + 1)'(NPIX);

  state_e               state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [FLUSH_W-1:0]   flush_q, flush_d;
  logic [TMO_W-1:0]     wait_q, wait_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic                 rd_done_q, rd_done_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 res_got_q, res_got_d;
  logic                 err_q, err_d;
  logic [9*PIX_W-1:0]   kernel_q, kernel_d;
  logic [2*PIX_W-1:0]   result_q, result_d;

  logic                 rd_issue;
  logic                 res_take;
  logic                 wr_ok;

  // Writes land only while idle; a write in the same cycle as an accepted
  // start still completes, so that frame streams the new value.
  assign wr_ok = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < NPIX_LIM);

  frame_buffer #(
    .WIDTH  (PIX_W),
    .DEPTH  (NPIX),
    .ADDR_W (ADDR_W)
  ) u_frame_buffer (
    .clk     (axi_clk),
    .rst_n   (axi_reset_n),
    .we_i    (wr_ok),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (rd_issue),
    .raddr_i (rd_addr_q),
    .rdata_o (o_data)
  );

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    gap_d     = gap_q;
    flush_d   = flush_q;
    wait_d    = wait_q;
    rd_addr_d = rd_addr_q;
    rd_done_d = rd_done_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    res_got_d = res_got_q;
    err_d     = err_q;
    kernel_d  = kernel_q;
    result_d  = result_q;
    rd_issue  = 1'b0;

    // Only the first result of a frame is kept, whether it arrives while
    // pixels are still going out or afterwards.
    res_take = ((state_q == STREAM) || (state_q == WAIT)) && res_valid && !res_got_q;
    if (res_take) begin
      result_d  = res_data;
      res_got_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          kernel_d  = kernel_vals_in;
          result_d  = '0;
          err_d     = 1'b0;
          res_got_d = 1'b0;
          flush_d   = '0;
          wait_d    = '0;
          col_d     = '0;
          row_d     = '0;
          gap_d     = '0;
          rd_addr_d = '0;
          rd_done_d = 1'b0;
          state_d   = FLUSH;
        end
      end

      FLUSH: begin
        if (flush_q == LAST_FLUSH) begin
          state_d = KLOAD;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end

      KLOAD: begin
        // Address 0 is read here so the first pixel is valid on the first
        // STREAM cycle.
        rd_issue = 1'b1;
        state_d  = STREAM;
      end

      STREAM: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (!rd_done_q) begin
          rd_issue = 1'b1;
        end
        // last_q marks the cycle presenting the final pixel.
        if (last_q) begin
          state_d = (res_got_q || res_valid) ? DONE : WAIT;
        end
      end

      WAIT: begin
        // A result in the timeout cycle takes priority over the error.
        if (res_valid) begin
          state_d = DONE;
        end else if (wait_q == LAST_WAIT) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Read sequencing: after the last pixel of a row (other than the final
    // row) the gap counter is loaded, which suppresses reads for ROW_GAP
    // cycles and thereby produces the idle gap on the output one cycle later.
    if (rd_issue) begin
      valid_d = 1'b1;
      if (col_q == LAST_COL) begin
        col_d = '0;
        if (row_q == LAST_ROW) begin
          rd_done_d = 1'b1;
          last_d    = 1'b1;
        end else begin
          row_d     = row_q + 1'b1;
          gap_d     = GAP_LOAD;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end else begin
        col_d     = col_q + 1'b1;
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other, independent of process order.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, flags and captured values
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      col_q     <= '0;
      row_q     <= '0;
      gap_q     <= '0;
      flush_q   <= '0;
      wait_q    <= '0;
      rd_addr_q <= '0;
      rd_done_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      res_got_q <= 1'b0;
      err_q     <= 1'b0;
      kernel_q  <= '0;
      result_q  <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      gap_q     <= gap_d;
      flush_q   <= flush_d;
      wait_q    <= wait_d;
      rd_addr_q <= rd_addr_d;
      rd_done_q <= rd_done_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      res_got_q <= res_got_d;
      err_q     <= err_d;
      kernel_q  <= kernel_d;
      result_q  <= result_d;
    end
  end

  // Status outputs decode the state register directly, so an asynchronous
  // reset returns them to their idle values immediately.
  assign o_pipe_rst_n   = (state_q != FLUSH);
  assign o_kernel_reset = (state_q == KLOAD);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign o_data_valid   = valid_q;
  assign o_kernel_vals  = kernel_q;
  assign result         = result_q;
  assign o_error        = err_q;

endmodule : image_stream_tx

// File: tb/tb_image_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_image_stream_tx
// Self-checking bench for image_stream_tx on a 4x3 frame with a short timeout.
// Expected behaviour comes from a frame-level model: the buffer contents as an
// array, the output trace as a list of (valid, pixel) entries built from the
// row/gap rules, and the result/error outcome decided from when res_valid is
// driven.
// -----------------------------------------------------------------------------
module tb_image_stream_tx;

  localparam int IB    = 9;
  localparam int FB    = 4;
  localparam int IW    = 4;
  localparam int IH    = 3;
  localparam int GAP   = 2;
  localparam int FLUSH = 4;
  localparam int TMO   = 8;
  localparam int W     = IB + FB;
  localparam int N     = IW * IH;
  localparam int AW    = $clog2(N);
  localparam int KW    = 9 * W;
  localparam int RW    = 2 * W;
  localparam int L     = N + (IH - 1) * GAP;

  logic          axi_clk;
  logic          axi_reset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          start;
  logic [KW-1:0] kernel_vals_in;
  logic          o_pipe_rst_n;
  logic          o_kernel_reset;
  logic [KW-1:0] o_kernel_vals;
  logic          o_data_valid;
  logic [W-1:0]  o_data;
  logic          res_valid;
  logic [RW-1:0] res_data;
  logic [RW-1:0] result;
  logic          busy;
  logic          done;
  logic          o_error;

  image_stream_tx #(
    .INTEGER_BITS     (IB),
    .FIXED_POINT_BITS (FB),
    .IMG_WIDTH        (IW),
    .IMG_HEIGHT       (IH),
    .ROW_GAP          (GAP),
    .FLUSH_CYCLES     (FLUSH),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .axi_clk        (axi_clk),
    .axi_reset_n    (axi_reset_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .start          (start),
    .kernel_vals_in (kernel_vals_in),
    .o_pipe_rst_n   (o_pipe_rst_n),
    .o_kernel_reset (o_kernel_reset),
    .o_kernel_vals  (o_kernel_vals),
    .o_data_valid   (o_data_valid),
    .o_data         (o_data),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .result         (result),
    .busy           (busy),
    .done           (done),
    .o_error        (o_error)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] ref_mem [N];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [KW-1:0] rand_kernel();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[KW-1:0];
  endfunction

  // Fill the buffer: ramp when ramp=1, random otherwise. One write beyond the
  // frame is also issued and must have no effect.
  task automatic load_buffer(input bit ramp);
    for (int a = 0; a < N; a++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = ramp ? W'(a) : W'($urandom());
      ref_mem[a] = wr_data;
      @(negedge axi_clk);
    end
    wr_addr = AW'(N);
    wr_data = W'($urandom());
    @(negedge axi_clk);
    wr_en = 1'b0;
  endtask

  // One frame from start to the IDLE cycle after done. Called at a negedge
  // with the DUT idle.
  //   res_s / res_s2 : STREAM cycle indices where res_valid carries val_a / val_b (-1 = none)
  //   res_w          : WAIT cycle index where res_valid carries val_w (-1 or >= TMO = none)
  //   noise          : toggle start, kernel and writes while busy (all must be ignored)
  //   pre_wr         : write 13'h1FF to address 0 in the start cycle
  //   abort_at       : STREAM index at which reset is asserted (-1 = none)
  task automatic run_frame(input int res_s, input logic [RW-1:0] val_a,
                           input int res_s2, input logic [RW-1:0] val_b,
                           input int res_w, input logic [RW-1:0] val_w,
                           input bit noise, input bit pre_wr, input int abort_at);
    logic [KW-1:0] kern;
    logic [W-1:0]  held;
    logic [RW-1:0] exp_res;
    bit            exp_err;
    bit            got;
    bit            ev_q[$];
    logic [W-1:0]  ep_q[$];
    int            first_s;

    if (pre_wr) begin
      wr_en   = 1'b1;
      wr_addr = '0;
      wr_data = 13'h1FF;
      ref_mem[0] = 13'h1FF;
    end
    kern           = rand_kernel();
    kernel_vals_in = kern;
    start          = 1'b1;

    // Expected output trace: each row's pixels back to back, gaps between rows.
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        ev_q.push_back(1'b1);
        ep_q.push_back(ref_mem[r * IW + c]);
      end
      if (r != IH - 1) begin
        for (int g = 0; g < GAP; g++) begin
          ev_q.push_back(1'b0);
          ep_q.push_back('0);
        end
      end
    end

    // First stream-time result wins.
    first_s = -1;
    if (res_s >= 0) first_s = res_s;
    if (res_s2 >= 0 && (first_s < 0 || res_s2 < first_s)) first_s = res_s2;
    got     = (first_s >= 0);
    exp_res = !got ? '0 : (first_s == res_s) ? val_a : val_b;
    exp_err = 1'b0;

    @(negedge axi_clk);
    start = 1'b0;
    wr_en = 1'b0;
    if (noise) kernel_vals_in = ~kern;

    for (int f = 0; f < FLUSH; f++) begin
      check("flush_pipe_rst_n", o_pipe_rst_n, 1'b0);
      check("flush_busy", busy, 1'b1);
      check("flush_valid", o_data_valid, 1'b0);
      check("flush_kreset", o_kernel_reset, 1'b0);
      if (f == 0) begin
        check("start_error_clear", o_error, 1'b0);
        check("start_result_clear", result, '0);
        check("kernel_capture", o_kernel_vals, kern);
      end
      @(negedge axi_clk);
    end

    check("kload_kreset", o_kernel_reset, 1'b1);
    check("kload_pipe_rst_n", o_pipe_rst_n, 1'b1);
    check("kload_valid", o_data_valid, 1'b0);
    @(negedge axi_clk);

    held = '0;
    for (int k = 0; k < L; k++) begin
      if (k == abort_at) begin
        axi_reset_n = 1'b0;
        #1;
        check("rst_valid", o_data_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pipe_rst_n", o_pipe_rst_n, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_kreset", o_kernel_reset, 1'b0);
        check("rst_kernel", o_kernel_vals, '0);
        start     = 1'b0;
        wr_en     = 1'b0;
        res_valid = 1'b0;
        return;
      end
      check($sformatf("stream_valid[%0d]", k), o_data_valid, ev_q[k]);
      if (ev_q[k]) begin
        check($sformatf("stream_data[%0d]", k), o_data, ep_q[k]);
        held = ep_q[k];
      end else begin
        check($sformatf("stream_hold[%0d]", k), o_data, held);
      end
      check("stream_pipe_rst_n", o_pipe_rst_n, 1'b1);
      check("stream_busy", busy, 1'b1);
      check("stream_done", done, 1'b0);

      res_valid = (k == res_s) || (k == res_s2);
      res_data  = (k == res_s) ? val_a : (k == res_s2) ? val_b : RW'($urandom());
      if (noise) begin
        start          = 1'($urandom_range(0, 1));
        kernel_vals_in = rand_kernel();
        wr_en          = 1'b1;
        wr_addr        = (k == 0) ? AW'(5) : AW'($urandom_range(0, N - 1));
        wr_data        = W'($urandom());
      end
      @(negedge axi_clk);
    end
    res_valid = 1'b0;
    start     = 1'b0;
    wr_en     = 1'b0;

    if (!got) begin
      bit fin;
      fin = 1'b0;
      for (int i = 0; i < TMO && !fin; i++) begin
        check("wait_busy", busy, 1'b1);
        check("wait_done", done, 1'b0);
        check("wait_valid", o_data_valid, 1'b0);
        check("wait_hold", o_data, held);
        check("wait_result", result, '0);
        check("wait_error", o_error, 1'b0);
        if (i == res_w) begin
          res_valid = 1'b1;
          res_data  = val_w;
          exp_res   = val_w;
          fin       = 1'b1;
        end else begin
          res_data = RW'($urandom());
        end
        @(negedge axi_clk);
        res_valid = 1'b0;
      end
      if (!fin) exp_err = 1'b1;
    end

    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b1);
    check("done_result", result, exp_res);
    check("done_error", o_error, exp_err);
    check("done_valid", o_data_valid, 1'b0);
    res_valid = 1'b1;
    res_data  = RW'($urandom());
    @(negedge axi_clk);
    res_valid = 1'b0;

    check("idle_done", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_result", result, exp_res);
    check("idle_error", o_error, exp_err);
    check("idle_pipe_rst_n", o_pipe_rst_n, 1'b1);
    check("idle_kernel", o_kernel_vals, kern);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_reset_n    = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    start          = 1'b0;
    kernel_vals_in = '0;
    res_valid      = 1'b0;
    res_data       = '0;

    #12;
    check("reset_pipe_rst_n", o_pipe_rst_n, 1'b1);
    check("reset_kreset", o_kernel_reset, 1'b0);
    check("reset_valid", o_data_valid, 1'b0);
    check("reset_data", o_data, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_error", o_error, 1'b0);
    check("reset_result", result, '0);
    check("reset_kernel", o_kernel_vals, '0);

    @(negedge axi_clk);
    axi_reset_n = 1'b1;
    @(negedge axi_clk);

    // Ramp frame, result 5 cycles into WAIT.
    load_buffer(1'b1);
    run_frame(-1, '0, -1, '0, 5, 26'h155_0AA, 1'b0, 1'b0, -1);

    // No result: timeout after TMO WAIT cycles.
    run_frame(-1, '0, -1, '0, -1, '0, 1'b0, 1'b0, -1);

    // Result during STREAM at pixel 6 (index 8), a second one at pixel 9
    // (index 13) is ignored; no WAIT dwell.
    run_frame(8, 26'h0ABC_DEF, 13, 26'h1234_567, 2, 26'h3FF_FFFF, 1'b0, 1'b0, -1);

    // Result coincides with the timeout cycle: result wins.
    run_frame(-1, '0, -1, '0, TMO - 1, 26'h2AA_AAA, 1'b0, 1'b0, -1);

    // Write together with start, plus busy-time noise that must be ignored.
    run_frame(-1, '0, -1, '0, 2, 26'h0F0_F0F, 1'b1, 1'b1, -1);

    // Async reset mid-stream, then a clean frame on fresh buffer contents.
    run_frame(-1, '0, -1, '0, 1, '0, 1'b1, 1'b0, 7);
    @(negedge axi_clk);
    check("after_rst_busy", busy, 1'b0);
    axi_reset_n = 1'b1;
    @(negedge axi_clk);
    load_buffer(1'b0);
    run_frame(-1, '0, -1, '0, 0, 26'h111_2222, 1'b0, 1'b0, -1);

    // Randomized frames.
    for (int t = 0; t < 8; t++) begin
      int mode;
      mode = $urandom_range(0, 2);
      load_buffer(1'b0);
      if (mode == 0) begin
        run_frame($urandom_range(0, L - 1), RW'($urandom()),
                  $urandom_range(0, L - 1), RW'($urandom()),
                  $urandom_range(0, TMO - 1), RW'($urandom()),
                  1'($urandom_range(0, 1)), 1'b0, -1);
      end else if (mode == 1) begin
        run_frame(-1, '0, -1, '0, $urandom_range(0, TMO + 1), RW'($urandom()),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      end else begin
        run_frame(-1, '0, -1, '0, -1, '0, 1'($urandom_range(0, 1)), 1'b0, -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_image_stream_tx
